// File: rtl/pkt_stream_sink.sv
// Stream sink: frames 64b/8b-ctrl packets, counts stats, captures last packet.
// Define RX_CSUM_EN to add the csum output (XOR of the last good packet).
module pkt_stream_sink #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH / 8,
   parameter int CAP_DEPTH  = 16,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [DATA_WIDTH-1:0]        in_data,
   input  logic [CTRL_WIDTH-1:0]        in_ctrl,
   input  logic                         in_wr,
   output logic                         in_rdy,
   input  logic                         sink_en,
   output logic                         pkt_done,
   output logic [CNT_WIDTH-1:0]         pkt_cnt,
   output logic [CNT_WIDTH-1:0]         word_cnt,
   output logic [CNT_WIDTH-1:0]         byte_cnt,
   output logic [CNT_WIDTH-1:0]         err_cnt,
   output logic [15:0]                  last_len,
   input  logic [$clog2(CAP_DEPTH)-1:0] cap_addr,
   output logic [DATA_WIDTH-1:0]        cap_data,
   output logic [CTRL_WIDTH-1:0]        cap_ctrl
`ifdef RX_CSUM_EN
   ,
   output logic [DATA_WIDTH-1:0]        csum
`endif
);

   localparam int AW = $clog2(CAP_DEPTH);
   localparam int PW = AW + 1;
   localparam int BW = $clog2(CTRL_WIDTH + 1);
   localparam logic [PW-1:0] CAP_FULL = PW'(CAP_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HDR,
      S_BODY,
      S_DROP
   } state_t;

   state_t r_state;
   state_t w_next;

   logic w_acc;
   logic w_ovf;
   logic w_is_hdr;
   logic w_is_body;
   logic w_is_eop;
   logic w_err;
   logic w_eop;
   logic w_cap_we;
   logic w_start;
   logic w_body_inc;

   logic [BW-1:0]         w_bytes;
   logic [19:0]           w_len;
   logic [15:0]           w_len_sat;
   logic [15:0]           r_body;
   logic [PW-1:0]         r_ptr;
   logic [AW-1:0]         w_waddr;
   logic                  w_wen;

   logic                  r_done;
   logic [CNT_WIDTH-1:0]  r_pkt_cnt;
   logic [CNT_WIDTH-1:0]  r_word_cnt;
   logic [CNT_WIDTH-1:0]  r_byte_cnt;
   logic [CNT_WIDTH-1:0]  r_err_cnt;
   logic [15:0]           r_last_len;
   logic [DATA_WIDTH-1:0] r_cap_d;
   logic [CTRL_WIDTH-1:0] r_cap_c;

   logic [DATA_WIDTH-1:0] r_mem_d [CAP_DEPTH];
   logic [CTRL_WIDTH-1:0] r_mem_c [CAP_DEPTH];

   assign in_rdy    = sink_en && !reset;
   assign w_acc     = in_wr && in_rdy;
   assign w_ovf     = in_wr && !in_rdy;
   assign w_is_hdr  = (in_ctrl == {CTRL_WIDTH{1'b1}});
   assign w_is_body = (in_ctrl == '0);
   assign w_is_eop  = !w_is_body &&
                      ((in_ctrl & (in_ctrl - CTRL_WIDTH'(1))) == '0);

   // Valid bytes in the EOP word: the one-hot bit index counts from the MSB.
   always_comb begin
      w_bytes = '0;
      for (int i = 0; i < CTRL_WIDTH; i++) begin
         if (in_ctrl[i]) w_bytes = BW'(CTRL_WIDTH - i);
      end
   end

   assign w_len     = 20'(r_body) * 20'(CTRL_WIDTH) + 20'(w_bytes);
   assign w_len_sat = (w_len[19:16] != '0) ? 16'hFFFF : w_len[15:0];

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_err      = 1'b0;
      w_eop      = 1'b0;
      w_cap_we   = 1'b0;
      w_start    = 1'b0;
      w_body_inc = 1'b0;
      if (w_acc) begin
         unique case (r_state)
            S_IDLE: begin
               if (w_is_hdr) begin
                  w_next   = S_HDR;
                  w_start  = 1'b1;
                  w_cap_we = 1'b1;
               end else begin
                  w_err = 1'b1;
                  if (w_is_body || w_is_eop) w_next = S_DROP;
               end
            end
            S_HDR: begin
               if (w_is_hdr) begin
                  w_cap_we = 1'b1;
               end else if (w_is_body) begin
                  w_next     = S_BODY;
                  w_cap_we   = 1'b1;
                  w_body_inc = 1'b1;
               end else if (w_is_eop) begin
                  w_next   = S_IDLE;
                  w_cap_we = 1'b1;
                  w_eop    = 1'b1;
               end else begin
                  w_next = S_DROP;
                  w_err  = 1'b1;
               end
            end
            S_BODY: begin
               if (w_is_body) begin
                  w_cap_we   = 1'b1;
                  w_body_inc = 1'b1;
               end else if (w_is_eop) begin
                  w_next   = S_IDLE;
                  w_cap_we = 1'b1;
                  w_eop    = 1'b1;
               end else begin
                  w_next = S_DROP;
                  w_err  = 1'b1;
               end
            end
            S_DROP: begin
               if (w_is_eop) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
         endcase
      end
   end

   // The first header always lands at index 0, whatever the pointer holds.
   assign w_waddr = w_start ? '0 : r_ptr[AW-1:0];
   assign w_wen   = w_cap_we && (w_start || (r_ptr < CAP_FULL));

   always_ff @(posedge clk) begin
      if (w_wen) begin
         r_mem_d[w_waddr] <= in_data;
         r_mem_c[w_waddr] <= in_ctrl;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr      <= '0;
         r_body     <= '0;
         r_done     <= 1'b0;
         r_pkt_cnt  <= '0;
         r_word_cnt <= '0;
         r_byte_cnt <= '0;
         r_err_cnt  <= '0;
         r_last_len <= '0;
         r_cap_d    <= '0;
         r_cap_c    <= '0;
      end else begin
         r_done  <= w_eop;
         r_cap_d <= r_mem_d[cap_addr];
         r_cap_c <= r_mem_c[cap_addr];
         if (w_start) begin
            r_ptr  <= PW'(1);
            r_body <= '0;
         end else begin
            if (w_cap_we && (r_ptr < CAP_FULL)) r_ptr <= r_ptr + PW'(1);
            if (w_body_inc && (r_body != 16'hFFFF)) r_body <= r_body + 16'd1;
         end
         if (w_acc) r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
         if (w_err || w_ovf) r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
         if (w_eop) begin
            r_pkt_cnt  <= r_pkt_cnt + CNT_WIDTH'(1);
            r_last_len <= w_len_sat;
            r_byte_cnt <= r_byte_cnt + CNT_WIDTH'(w_len_sat);
         end
      end
   end

`ifdef RX_CSUM_EN
   logic [DATA_WIDTH-1:0] r_csum_acc;
   logic [DATA_WIDTH-1:0] r_csum;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_csum_acc <= '0;
         r_csum     <= '0;
      end else begin
         if (w_start)       r_csum_acc <= in_data;
         else if (w_cap_we) r_csum_acc <= r_csum_acc ^ in_data;
         if (w_eop)         r_csum     <= r_csum_acc ^ in_data;
      end
   end

   assign csum = r_csum;
`endif

   assign pkt_done = r_done;
   assign pkt_cnt  = r_pkt_cnt;
   assign word_cnt = r_word_cnt;
   assign byte_cnt = r_byte_cnt;
   assign err_cnt  = r_err_cnt;
   assign last_len = r_last_len;
   assign cap_data = r_cap_d;
   assign cap_ctrl = r_cap_c;

endmodule

// File: tb/tb_pkt_stream_sink.sv
// Randomized bench for pkt_stream_sink against a queue-based packet model.
// Directed test-plan cases pin the model with literal expectations.
module tb_pkt_stream_sink;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] in_data;
   logic [7:0]  in_ctrl;
   logic        in_wr;
   logic        in_rdy;
   logic        sink_en;
   logic        pkt_done;
   logic [31:0] pkt_cnt;
   logic [31:0] word_cnt;
   logic [31:0] byte_cnt;
   logic [31:0] err_cnt;
   logic [15:0] last_len;
   logic [3:0]  cap_addr;
   logic [63:0] cap_data;
   logic [7:0]  cap_ctrl;
`ifdef RX_CSUM_EN
   logic [63:0] csum;
`endif

   pkt_stream_sink dut (
      .clk      (clk),
      .reset    (reset),
      .in_data  (in_data),
      .in_ctrl  (in_ctrl),
      .in_wr    (in_wr),
      .in_rdy   (in_rdy),
      .sink_en  (sink_en),
      .pkt_done (pkt_done),
      .pkt_cnt  (pkt_cnt),
      .word_cnt (word_cnt),
      .byte_cnt (byte_cnt),
      .err_cnt  (err_cnt),
      .last_len (last_len),
      .cap_addr (cap_addr),
      .cap_data (cap_data),
      .cap_ctrl (cap_ctrl)
`ifdef RX_CSUM_EN
      ,
      .csum     (csum)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model state: the words of the open packet, and a discard flag.
   logic [63:0] q_d[$];
   logic [7:0]  q_c[$];
   bit          m_on = 0;
   bit          m_drop;
   bit          m_cap_valid;
   int          m_cap_n;
   logic [63:0] m_cap_d [16];
   logic [7:0]  m_cap_c [16];

   logic        e_rdy;
   logic        e_done;
   logic [31:0] e_pkt, e_word, e_byte, e_err;
   logic [15:0] e_len;
   bit          e_cap_chk;
   logic [63:0] e_cap_d;
   logic [7:0]  e_cap_c;
   logic [63:0] e_csum;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic finish_pkt(input logic [7:0] c, input int nb);
      int len;
      len = 8 * nb + 8 - $clog2(c);
      if (len > 65535) len = 65535;
      e_len  = 16'(len);
      e_byte = e_byte + 32'(len);
      e_pkt  = e_pkt + 1;
      e_done = 1'b1;
      m_cap_n = (q_d.size() > 16) ? 16 : q_d.size();
      for (int i = 0; i < m_cap_n; i++) begin
         m_cap_d[i] = q_d[i];
         m_cap_c[i] = q_c[i];
      end
      m_cap_valid = 1;
      e_csum = '0;
      foreach (q_d[i]) e_csum = e_csum ^ q_d[i];
      q_d.delete();
      q_c.delete();
   endtask

   task automatic accept(input logic [63:0] d, input logic [7:0] c);
      bit hdr, body, eop;
      int nb;
      hdr  = (c == 8'hFF);
      body = (c == 8'h00);
      eop  = ($countones(c) == 1);
      nb   = 0;
      foreach (q_c[i]) if (q_c[i] == 8'h00) nb++;
      e_word = e_word + 1;
      if (m_drop) begin
         if (eop) m_drop = 0;
      end else if (q_c.size() == 0) begin
         if (hdr) begin
            q_d.push_back(d);
            q_c.push_back(c);
            m_cap_valid = 0;
         end else begin
            e_err = e_err + 1;
            if (body || eop) m_drop = 1;
         end
      end else if (body || (hdr && nb == 0)) begin
         q_d.push_back(d);
         q_c.push_back(c);
      end else if (eop) begin
         q_d.push_back(d);
         q_c.push_back(c);
         finish_pkt(c, nb);
      end else begin
         e_err  = e_err + 1;
         m_drop = 1;
         q_d.delete();
         q_c.delete();
      end
   endtask

   task automatic model(input logic rst, input logic wr, input logic en,
                        input logic [63:0] d, input logic [7:0] c,
                        input logic [3:0] a);
      e_done = 1'b0;
      if (rst) begin
         e_rdy = 0; e_pkt = 0; e_word = 0; e_byte = 0; e_err = 0;
         e_len = 0; e_csum = 0;
         m_drop = 0; m_cap_valid = 0; m_cap_n = 0;
         q_d.delete();
         q_c.delete();
         e_cap_chk = 1; e_cap_d = 0; e_cap_c = 0;
      end else begin
         e_rdy = en;
         e_cap_chk = m_cap_valid && (int'(a) < m_cap_n);
         if (e_cap_chk) begin
            e_cap_d = m_cap_d[a];
            e_cap_c = m_cap_c[a];
         end
         if (wr && !en) e_err = e_err + 1;
         else if (wr)   accept(d, c);
      end
   endtask

   // Inputs change on the falling edge; outputs are checked 2ns after rising.
   task automatic step(input logic rst, input logic wr, input logic en,
                       input logic [63:0] d, input logic [7:0] c,
                       input logic [3:0] a);
      reset = rst; in_wr = wr; sink_en = en;
      in_data = d; in_ctrl = c; cap_addr = a;
      model(rst, wr, en, d, c, a);
      m_on = 1;
      @(negedge clk);
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [3:0] ra();
      return 4'($urandom_range(0, 15));
   endfunction

   task automatic word(input logic [63:0] d, input logic [7:0] c);
      step(1'b0, 1'b1, 1'b1, d, c, ra());
   endtask

   task automatic idle(input logic [3:0] a);
      step(1'b0, 1'b0, 1'b1, rnd64(), 8'($urandom), a);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, '0, '0, '0);
   endtask

   always @(posedge clk) begin
      #2;
      if (m_on) begin
         chk("in_rdy", in_rdy, e_rdy);
         chk("pkt_done", pkt_done, e_done);
         chk("pkt_cnt", pkt_cnt, e_pkt);
         chk("word_cnt", word_cnt, e_word);
         chk("byte_cnt", byte_cnt, e_byte);
         chk("err_cnt", err_cnt, e_err);
         chk("last_len", last_len, e_len);
         if (e_cap_chk) begin
            chk("cap_data", cap_data, e_cap_d);
            chk("cap_ctrl", cap_ctrl, e_cap_c);
         end
`ifdef RX_CSUM_EN
         chk("csum", csum, e_csum);
`endif
      end
   end

   task automatic rnd_pkt();
      int nh, nb;
      logic [7:0] c;
      nh = $urandom_range(1, 2);
      nb = $urandom_range(0, 20);
      for (int i = 0; i < nh + nb + 1; i++) begin
         if (i < nh)           c = 8'hFF;
         else if (i < nh + nb) c = 8'h00;
         else                  c = 8'(1 << $urandom_range(0, 7));
         while ($urandom_range(0, 9) == 0)
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0, rnd64(), c, ra());
         if ($urandom_range(0, 7) == 0) idle(ra());
         word(rnd64(), c);
      end
   endtask

   initial begin
      reset = 1'b1; in_wr = 1'b0; sink_en = 1'b0;
      in_data = '0; in_ctrl = '0; cap_addr = '0;
      @(negedge clk);
      do_reset();
      do_reset();
      chk("rst_in_rdy", in_rdy, 1'b0);
      chk("rst_pkt_cnt", pkt_cnt, 32'd0);
      chk("rst_err_cnt", err_cnt, 32'd0);
      chk("rst_cap_data", cap_data, 64'd0);

      // Basic packet: 1 header, 3 body, EOP 0x10 (4 bytes).
      word(64'hA0, 8'hFF);
      for (int i = 1; i <= 3; i++) word(64'hA0 + 64'(i), 8'h00);
      word(64'hA4, 8'h10);
      chk("t1_done", pkt_done, 1'b1);
      chk("t1_pkt", pkt_cnt, 32'd1);
      chk("t1_words", word_cnt, 32'd5);
      chk("t1_len", last_len, 16'd28);
      chk("t1_bytes", byte_cnt, 32'd28);
      chk("t1_err", err_cnt, 32'd0);
      chk("t1_model_len", e_len, 16'd28);
      idle(4'd0);
      chk("t1_done_low", pkt_done, 1'b0);
      for (int i = 1; i <= 4; i++) idle(4'(i));
      idle(4'd3);
      chk("t1_cap3", cap_data, 64'hA3);
      idle(4'd4);
      chk("t1_cap4_ctrl", cap_ctrl, 8'h10);

      // Body word in IDLE -> DROP until 0x01, then a good packet.
      do_reset();
      word(64'h1, 8'h00);
      word(64'h2, 8'h00);
      word(64'h3, 8'hFF);
      word(64'h4, 8'h01);
      word(64'h10, 8'hFF);
      word(64'h11, 8'h00);
      word(64'h12, 8'h00);
      word(64'h13, 8'h01);
      chk("t2_err", err_cnt, 32'd1);
      chk("t2_pkt", pkt_cnt, 32'd1);
      chk("t2_len", last_len, 16'd24);

      // 20-word packet: capture saturates after 16 words.
      do_reset();
      word(64'h300, 8'hFF);
      for (int i = 1; i <= 18; i++) word(64'h300 + 64'(i), 8'h00);
      word(64'h313, 8'h80);
      chk("t3_pkt", pkt_cnt, 32'd1);
      chk("t3_len", last_len, 16'd145);
      chk("t3_model_n", 32'(m_cap_n), 32'd16);
      idle(4'd15);
      chk("t3_cap15", cap_data, 64'h30F);
      idle(4'd0);
      chk("t3_cap0", cap_data, 64'h300);

      // Writes while disabled mid-packet are errors; packet still completes.
      do_reset();
      word(64'h40, 8'hFF);
      word(64'h41, 8'h00);
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 1'b0, 64'h99, 8'h00, 4'd0);
      chk("t4_rdy", in_rdy, 1'b0);
      word(64'h42, 8'h00);
      word(64'h43, 8'h80);
      chk("t4_err", err_cnt, 32'd3);
      chk("t4_pkt", pkt_cnt, 32'd1);
      chk("t4_len", last_len, 16'd17);

      // Reset mid-body, then a fresh packet.
      word(64'h50, 8'hFF);
      word(64'h51, 8'h00);
      word(64'h52, 8'h00);
      do_reset();
      word(64'h60, 8'hFF);
      word(64'h61, 8'h00);
      word(64'h62, 8'h02);
      chk("t5_pkt", pkt_cnt, 32'd1);
      chk("t5_words", word_cnt, 32'd3);
      chk("t5_len", last_len, 16'd15);
      chk("t5_err", err_cnt, 32'd0);

`ifdef RX_CSUM_EN
      do_reset();
      word(64'h1, 8'hFF);
      word(64'h2, 8'h00);
      word(64'h4, 8'h01);
      idle(4'd0);
      chk("csum_good", csum, 64'h7);
      word(64'h8, 8'h00);
      word(64'h9, 8'h00);
      word(64'hA, 8'h01);
      idle(4'd0);
      chk("csum_drop", csum, 64'h7);
`endif

      do_reset();
      for (int it = 0; it < 250; it++) begin
         int k;
         k = $urandom_range(0, 19);
         if (k < 12) begin
            rnd_pkt();
         end else if (k < 16) begin
            case ($urandom_range(0, 2))
               0:       word(rnd64(), 8'h00);
               1:       word(rnd64(), 8'(1 << $urandom_range(0, 7)));
               default: word(rnd64(), 8'($urandom));
            endcase
         end else if (k == 16) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 rnd64(), 8'($urandom), ra());
         end else begin
            for (int j = 0; j < 3; j++) idle(ra());
         end
      end
      idle(4'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
